// File: rtl/lib_pkg.sv
// lib_pkg: shared state type and shift-direction constants for the frame serialiser
package lib_pkg;
  typedef enum logic {IDLE, SHIFT} fsr_state_t;
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;
endpackage

// File: rtl/bidir_shift_reg.sv
// bidir_shift_reg: loadable shift register filling from the end opposite the serial output
module bidir_shift_reg
  import lib_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = MSB_FIRST_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  always_comb begin
    shreg_d = clr ? '0 :
              load ? d :
              !shift ? shreg_q :
              (MSB_FIRST == LSB_FIRST_C) ? {si, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], si};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shreg_q <= '0;
    else shreg_q <= shreg_d;
  end
  assign q  = shreg_q;
  assign so = (MSB_FIRST == LSB_FIRST_C) ? shreg_q[0] : shreg_q[WIDTH-1];
endmodule

// File: rtl/frame_shift_reg.sv
// frame_shift_reg: full-duplex serialiser/deserialiser clocked by a bit strobe
module frame_shift_reg
  import lib_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = MSB_FIRST_C,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             bit_en,
  output logic             sdo,
  input  logic             sdi,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  fsr_state_t       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d, q, rx_word;
  logic             rx_valid_q, rx_valid_d, load, shift, last, so;
  bidir_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .shift(shift),
    .d(tx_data), .si(sdi), .q(q), .so(so)
  );
  // rx_word mirrors the shift register's post-strobe contents so the completed word is captured on the final strobe edge
  always_comb begin
    load       = (state_q == IDLE) && tx_valid;
    shift      = (state_q == SHIFT) && bit_en;
    last       = shift && (bit_cnt_q == CNT_W'(WIDTH - 1));
    rx_word    = (MSB_FIRST == LSB_FIRST_C) ? {sdi, q[WIDTH-1:1]} : {q[WIDTH-2:0], sdi};
    state_d    = clr ? IDLE : load ? SHIFT : last ? IDLE : state_q;
    bit_cnt_d  = (clr || load || last) ? '0 : shift ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    rx_data_d  = clr ? '0 : last ? rx_word : rx_data_q;
    rx_valid_d = !clr && last;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT);
  assign sdo      = busy ? so : IDLE_LEVEL;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: doc/frame_shift_reg.md
Name: frame_shift_reg

Overview:
- Parametrised full-duplex serialiser/deserialiser: the successor to the fixed-direction PISO/SIPO registers.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per `bit_en` strobe, MSB- or LSB-first.
- Samples `sdi` on the same strobes and presents the assembled word with a one-cycle `rx_valid` pulse.
- Sits between sensor/link interfaces (SPI-style) and the logger datapath.

Parameters:
- WIDTH, 8, frame length in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = shift MSB out first and fill from LSB; 0 = LSB out first and fill from MSB.
- IDLE_LEVEL, 1'b1, level driven on `sdo` while idle.
- CNT_W (localparam), $clog2(WIDTH+1), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; abort frame, return to IDLE.
- tx_data  input  WIDTH  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block accepts a word (high only in IDLE).
- bit_en  input  1  single-cycle bit strobe (baud tick).
- sdo  output  1  serial data out.
- sdi  input  1  serial data in.
- rx_data  output  WIDTH  last completely received word.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- busy  output  1  high in SHIFT.

Behaviour:
- States: IDLE, SHIFT. Registers: `shreg[WIDTH]`, `bit_cnt[CNT_W]`, `rx_data`, `rx_valid`.
- Reset (rst_n=0, asynchronous) and clr=1 (synchronous, highest priority) have the same effect:
  - state=IDLE, shreg=0, bit_cnt=0, rx_data=0, rx_valid=0.
  - Resulting outputs: tx_ready=1, busy=0, sdo=IDLE_LEVEL.
  - A frame in progress is discarded; no rx_valid is produced for it.
- `tx_ready` = (state==IDLE), combinational from state. `busy` = (state==SHIFT).
- IDLE:
  - sdo=IDLE_LEVEL; bit_en is ignored.
  - On tx_valid & tx_ready at edge N: shreg<=tx_data, bit_cnt<=0, state<=SHIFT.
- SHIFT:
  - sdo = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. The first bit is therefore on sdo from cycle N+1, before the first strobe.
  - tx_valid is ignored; the word is not consumed because tx_ready=0.
  - Cycles with bit_en=0 hold all state.
  - On bit_en with MSB_FIRST: shreg<={shreg[WIDTH-2:0], sdi}.
  - On bit_en with LSB_FIRST: shreg<={sdi, shreg[WIDTH-1:1]}.
  - Every strobe increments bit_cnt.
- Last bit: on bit_en with bit_cnt==WIDTH-1:
  - rx_data<=the post-shift shreg value, which holds received bits in received order.
  - rx_valid<=1 for exactly one cycle; state<=IDLE; bit_cnt<=0.
- Latency:
  - Handshake at edge N; WIDTH strobes follow.
  - rx_valid is high in the cycle after the edge that samples the final strobe.
  - tx_ready returns high in that same cycle, so a new handshake can occur in that cycle.
  - Minimum frame = WIDTH+1 cycles when bit_en is tied high.
- rx_data holds its value until the next completed frame or a reset/clear. rx_valid is never asserted in any other case.
- clr coincident with the last strobe: clr wins; rx_valid=0 and rx_data=0.
- bit_en and tx_valid in the same cycle in IDLE: the load is performed and the strobe is not counted.
- bit_cnt never exceeds WIDTH-1; no wrap-around occurs within a frame.

Decomposition:
- Shared package `lib_pkg` holds:
  - `typedef enum logic {IDLE, SHIFT} fsr_state_t`.
  - Direction constants `MSB_FIRST_C=1`, `LSB_FIRST_C=0`.
- One sub-module, `bidir_shift_reg #(WIDTH, MSB_FIRST)`:
  - Ports: load, shift, D, serial in, Q, serial out.
  - Asynchronous rst_n and synchronous clr, same priority as the parent.
- FSM, bit counter and rx capture stay in frame_shift_reg.

Test Plan:
- WIDTH=8, MSB_FIRST=1, sdi looped to sdo, bit_en every 3rd cycle, tx_data=8'hA5:
  - sdo sequence is 1,0,1,0,0,1,0,1.
  - rx_valid is a single pulse and rx_data=8'hA5.
  - tx_ready=0 from the cycle after the handshake until the rx_valid cycle.
- MSB_FIRST=0, tx_data=8'h01, sdi driven with bits of 8'h3C LSB-first:
  - sdo is 1 then seven 0s.
  - rx_data=8'h3C.
- bit_en tied high, two words 8'hFF and 8'h00 offered back-to-back:
  - The second handshake occurs in the rx_valid cycle.
  - Each frame takes 9 cycles; rx_data becomes 8'hFF, then 8'h00.
- clr asserted after 4 strobes of 8'hC3:
  - Next cycle: state IDLE, sdo=IDLE_LEVEL, tx_ready=1, no rx_valid.
  - A following frame of 8'h5A completes correctly.
- rst_n pulsed low mid-cycle during SHIFT:
  - Outputs reach reset values immediately, without waiting for a clock edge.
  - rx_data=0.
- tx_valid held high during SHIFT with changing tx_data:
  - The in-flight frame is unaffected.
  - The held word is accepted only when tx_ready rises.
